// File: rtl/game_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : game_pkg
// Purpose  : shared states and drawer job codes for the game sequencer
// Revision : 1.0
// ------------------------------------------------------------------
package game_pkg;

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_DRAW_START  = 4'd1,
      S_WAIT_SEL    = 4'd2,
      S_DRAW_MAP    = 4'd3,
      S_START_TIMER = 4'd4,
      S_ERASE       = 4'd5,
      S_UPDATE      = 4'd6,
      S_DRAW_CAR    = 4'd7,
      S_FRAME_WAIT  = 4'd8,
      S_DRAW_OVER   = 4'd9,
      S_OVER_WAIT   = 4'd10
   } state_t;

   localparam int DRAW_SEL_W = 3;

   localparam logic [DRAW_SEL_W-1:0] DRAW_START = 3'd0;
   localparam logic [DRAW_SEL_W-1:0] DRAW_MAP   = 3'd1;
   localparam logic [DRAW_SEL_W-1:0] DRAW_ERASE = 3'd2;
   localparam logic [DRAW_SEL_W-1:0] DRAW_CAR   = 3'd3;
   localparam logic [DRAW_SEL_W-1:0] DRAW_OVER  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/frame_delay_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : frame_delay_counter
// Purpose  : loadable down-counter that parks at zero, used for frame pacing
// Revision : 1.0
// ------------------------------------------------------------------
module frame_delay_counter #(
   parameter int FRAME_DELAY = 833333,
   parameter int DELAY_W     = $clog2(FRAME_DELAY)
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam logic [DELAY_W-1:0] c_LOAD = DELAY_W'(FRAME_DELAY - 1);

   logic [DELAY_W-1:0] r_count;

   // Saturates at zero so an idle enable can never wrap into a new period.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= c_LOAD;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - DELAY_W'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : game_flow_ctrl
// Purpose  : top-level game sequencer driving the shared drawer and timers
// Revision : 1.0
// ------------------------------------------------------------------
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int NUM_MAPS    = 4,
   parameter int MAP_W       = $clog2(NUM_MAPS),
   parameter int FRAME_DELAY = 833333,
   parameter int DELAY_W     = $clog2(FRAME_DELAY)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NUM_MAPS-1:0]   btn,
   input  logic                  draw_done,
   input  logic                  time_up,
   output logic                  draw_go,
   output logic [DRAW_SEL_W-1:0] draw_sel,
   output logic [MAP_W-1:0]      map_idx,
   output logic                  timer_clr,
   output logic                  timer_en,
   output logic                  car_update,
   output logic                  game_over
);

   state_t              r_state;
   state_t              w_next;
   logic [NUM_MAPS-1:0] r_btn_q;
   logic [NUM_MAPS-1:0] w_press;
   logic [MAP_W-1:0]    r_map_idx;
   logic                r_end_pend;
   logic                w_cnt_load;
   logic                w_cnt_en;
   logic                w_cnt_zero;

   function automatic logic [MAP_W-1:0] f_lowest(input logic [NUM_MAPS-1:0] v);
      f_lowest = '0;
      for (int i = NUM_MAPS - 1; i >= 0; i--) begin
         if (v[i]) begin
            f_lowest = MAP_W'(i);
         end
      end
   endfunction

   assign w_press    = btn & ~r_btn_q;
   assign w_cnt_load = (r_state == S_DRAW_CAR) && draw_done;
   assign w_cnt_en   = (r_state == S_FRAME_WAIT);
   assign map_idx    = r_map_idx;

   frame_delay_counter #(
      .FRAME_DELAY (FRAME_DELAY),
      .DELAY_W     (DELAY_W)
   ) u_frame_cnt (
      .clk    (clk),
      .resetn (resetn),
      .load   (w_cnt_load),
      .en     (w_cnt_en),
      .zero   (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A timeout seen mid-frame is remembered so the frame still finishes drawing.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_btn_q    <= '0;
         r_map_idx  <= '0;
         r_end_pend <= 1'b0;
      end else begin
         r_btn_q <= btn;
         if ((r_state == S_WAIT_SEL) && (|w_press)) begin
            r_map_idx <= f_lowest(w_press);
         end
         if (r_state == S_START_TIMER) begin
            r_end_pend <= 1'b0;
         end else if (timer_en && time_up) begin
            r_end_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      draw_go    = 1'b0;
      draw_sel   = DRAW_START;
      timer_clr  = 1'b0;
      timer_en   = 1'b0;
      car_update = 1'b0;
      game_over  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next = S_DRAW_START;
         end
         S_DRAW_START: begin
            draw_go  = 1'b1;
            draw_sel = DRAW_START;
            if (draw_done) w_next = S_WAIT_SEL;
         end
         S_WAIT_SEL: begin
            if (|w_press) w_next = S_DRAW_MAP;
         end
         S_DRAW_MAP: begin
            draw_go  = 1'b1;
            draw_sel = DRAW_MAP;
            if (draw_done) w_next = S_START_TIMER;
         end
         S_START_TIMER: begin
            timer_clr = 1'b1;
            w_next    = S_ERASE;
         end
         S_ERASE: begin
            draw_go  = 1'b1;
            draw_sel = DRAW_ERASE;
            timer_en = 1'b1;
            if (draw_done) w_next = S_UPDATE;
         end
         S_UPDATE: begin
            car_update = 1'b1;
            timer_en   = 1'b1;
            w_next     = S_DRAW_CAR;
         end
         S_DRAW_CAR: begin
            draw_go  = 1'b1;
            draw_sel = DRAW_CAR;
            timer_en = 1'b1;
            if (draw_done) w_next = S_FRAME_WAIT;
         end
         S_FRAME_WAIT: begin
            timer_en = 1'b1;
            if (w_cnt_zero) begin
               w_next = (r_end_pend || time_up) ? S_DRAW_OVER : S_ERASE;
            end
         end
         S_DRAW_OVER: begin
            draw_go   = 1'b1;
            draw_sel  = DRAW_OVER;
            game_over = 1'b1;
            if (draw_done) w_next = S_OVER_WAIT;
         end
         S_OVER_WAIT: begin
            game_over = 1'b1;
            if (|w_press) w_next = S_DRAW_START;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : tb_game_flow_ctrl
// Purpose  : randomized scoreboard bench for game_flow_ctrl
// Revision : 1.0
// ------------------------------------------------------------------
module tb_game_flow_ctrl;

   localparam int NM     = 4;
   localparam int FD     = 4;
   localparam int LAT    = 3;
   localparam int PERIOD = LAT + 1 + LAT + FD;

   // kind: 0 draw request, 1 timer clear, 2 car update
   typedef struct {
      int kind;
      int sel;
      int idx;
      int period;
   } ev_t;

   logic          clk       = 1'b0;
   logic          resetn    = 1'b0;
   logic [NM-1:0] btn       = '0;
   logic          draw_done = 1'b0;
   logic          time_up   = 1'b0;
   logic          draw_go;
   logic [2:0]    draw_sel;
   logic [1:0]    map_idx;
   logic          timer_clr;
   logic          timer_en;
   logic          car_update;
   logic          game_over;

   ev_t expq[$];
   int  checks   = 0;
   int  errors   = 0;
   int  n_upd    = 0;
   int  cyc      = 0;
   int  last_upd = -1;
   int  cur_idx  = 0;
   int  run      = 0;
   bit  loop_f   = 1'b0;
   bit  prev_go  = 1'b0;
   bit  prev_done = 1'b0;

   always #5 clk = ~clk;

   game_flow_ctrl #(
      .NUM_MAPS    (NM),
      .FRAME_DELAY (FD)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .btn        (btn),
      .draw_done  (draw_done),
      .time_up    (time_up),
      .draw_go    (draw_go),
      .draw_sel   (draw_sel),
      .map_idx    (map_idx),
      .timer_clr  (timer_clr),
      .timer_en   (timer_en),
      .car_update (car_update),
      .game_over  (game_over)
   );

   // Drawer: completes a job in the LAT-th cycle of its request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (draw_go === 1'b1) run++;
         else run = 0;
         draw_done = (run == LAT);
      end
   end

   function automatic int lowest(input logic [NM-1:0] v);
      for (int i = 0; i < NM; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [NM-1:0] nz();
      logic [NM-1:0] v;
      do v = NM'($urandom); while (v == '0);
      return v;
   endfunction

   task automatic push(input int k, input int s, input int i, input int p);
      ev_t e;
      e.kind = k; e.sel = s; e.idx = i; e.period = p;
      expq.push_back(e);
   endtask

   task automatic got(input int k, input int s, input int i, input int p, input int te, input int go);
      ev_t e;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d sel=%0d idx=%0d, required no event", k, s, i);
      end else begin
         e = expq.pop_front();
         if (k != e.kind ||
             (k == 0 && (s != e.sel || i != e.idx ||
                         te != int'(e.sel == 2 || e.sel == 3) || go != int'(e.sel == 4))) ||
             (k == 2 && e.period >= 0 && p != e.period)) begin
            errors++;
            $display("FAIL event: got kind=%0d sel=%0d idx=%0d period=%0d timer_en=%0d game_over=%0d, required kind=%0d sel=%0d idx=%0d period=%0d",
                     k, s, i, p, te, go, e.kind, e.sel, e.idx, e.period);
         end
      end
   endtask

   // Monitor: turns output activity into events and checks cycle invariants.
   always @(negedge clk) begin
      int per;
      cyc++;
      if (!resetn) begin
         loop_f    = 1'b0;
         last_upd  = -1;
         prev_go   = 1'b0;
         prev_done = 1'b0;
      end else begin
         checks++;
         if (!draw_go && draw_sel != 3'd0) begin
            errors++;
            $display("FAIL sel_idle: got draw_sel=%0d with draw_go=0, required 0", draw_sel);
         end
         if (loop_f) begin
            if (draw_go && draw_sel == 3'd4) begin
               loop_f = 1'b0;
            end else begin
               checks++;
               if (timer_en !== 1'b1 || game_over !== 1'b0) begin
                  errors++;
                  $display("FAIL loop_enable: got timer_en=%0b game_over=%0b, required 1 0", timer_en, game_over);
               end
            end
         end
         if (draw_go && !prev_go)
            got(0, int'(draw_sel), int'(map_idx), -1, int'(timer_en), int'(game_over));
         if (prev_go && !draw_go) begin
            checks++;
            if (!prev_done) begin
               errors++;
               $display("FAIL go_hold: got draw_go drop without draw_done, required hold until done");
            end
         end
         if (timer_clr) begin
            got(1, 0, 0, -1, 0, 0);
            last_upd = -1;
            loop_f   = 1'b1;
         end
         if (car_update) begin
            per      = (last_upd < 0) ? -1 : (cyc - last_upd);
            last_upd = cyc;
            n_upd++;
            got(2, 0, 0, per, 0, 0);
         end
         prev_go   = draw_go;
         prev_done = draw_done;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_q_empty(input string what);
      int n = 0;
      while (expq.size() != 0 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d events outstanding, required 0", what, expq.size());
      end
   endtask

   task automatic wait_go_low(input string what);
      int n = 0;
      while (draw_go && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (draw_go) begin
         errors++;
         $display("FAIL %s_end: got draw_go=1, required 0", what);
      end
   endtask

   task automatic restart(input logic [NM-1:0] pat);
      push(0, 0, cur_idx, -1);
      btn = pat;
      step();
      btn = '0;
      wait_q_empty("start_draw");
      wait_go_low("start_draw");
   endtask

   // One game: select from pat, play nfr frames, end the last one with time_up.
   task automatic play(input logic [NM-1:0] pat, input int nfr, input bit noise);
      int tgt;
      int n;
      int off;
      bit lvl;
      cur_idx = lowest(pat);
      push(0, 1, cur_idx, -1);
      push(1, 0, 0, -1);
      for (int f = 0; f < nfr; f++) begin
         push(0, 2, cur_idx, -1);
         push(2, 0, 0, (f == 0) ? -1 : PERIOD);
         push(0, 3, cur_idx, -1);
      end
      push(0, 4, cur_idx, -1);
      btn = pat;
      step();
      btn = '0;
      tgt = n_upd + nfr;
      n   = 0;
      while (n_upd < tgt && n < PERIOD * nfr + 60) begin
         step();
         n++;
         if (noise && n_upd < tgt) btn = NM'($urandom);
      end
      btn = '0;
      checks++;
      if (n_upd < tgt) begin
         errors++;
         $display("FAIL frame_count: got %0d car updates, required %0d", n_upd, tgt);
      end
      off = $urandom_range(0, LAT + FD);
      repeat (off) step();
      time_up = 1'b1;
      lvl     = 1'($urandom);
      if (!lvl) begin
         step();
         time_up = 1'b0;
      end
      wait_q_empty("game_over_draw");
      time_up = 1'b0;
      wait_go_low("over_draw");
      checks++;
      if (game_over !== 1'b1 || timer_en !== 1'b0 || car_update !== 1'b0) begin
         errors++;
         $display("FAIL over_wait: got game_over=%0b timer_en=%0b car_update=%0b, required 1 0 0",
                  game_over, timer_en, car_update);
      end
   endtask

   initial begin
      resetn = 1'b0;
      repeat (3) step();
      checks++;
      if ({draw_go, draw_sel, map_idx, timer_clr, timer_en, car_update, game_over} !== '0) begin
         errors++;
         $display("FAIL reset_state: got go=%0b sel=%0d idx=%0d clr=%0b en=%0b upd=%0b over=%0b, required all 0",
                  draw_go, draw_sel, map_idx, timer_clr, timer_en, car_update, game_over);
      end
      push(0, 0, 0, -1);
      resetn = 1'b1;
      wait_q_empty("first_start_draw");
      wait_go_low("first_start_draw");

      play(4'b0110, 3, 1'b0);

      // Restart, then hold btn[2] across the map-select entry.
      push(0, 0, cur_idx, -1);
      btn = 4'b1000;
      step();
      btn = 4'b0100;
      wait_q_empty("restart_draw");
      wait_go_low("restart_draw");
      repeat (8) step();
      checks++;
      if (draw_go !== 1'b0 || map_idx !== 2'(cur_idx)) begin
         errors++;
         $display("FAIL held_button: got draw_go=%0b map_idx=%0d, required 0 %0d", draw_go, map_idx, cur_idx);
      end
      btn = '0;
      step();
      play(4'b0100, 2, 1'b0);

      for (int g = 0; g < 5; g++) begin
         restart(nz());
         play(nz(), $urandom_range(1, 4), 1'b1);
      end

      restart(nz());
      play(nz() | 4'b0001, 3, 1'b1);

      // Final game: reset in the middle of the second frame's erase.
      restart(nz());
      cur_idx = 3;
      push(0, 1, 3, -1);
      push(1, 0, 0, -1);
      push(0, 2, 3, -1);
      push(2, 0, 0, -1);
      push(0, 3, 3, -1);
      push(0, 2, 3, -1);
      btn = 4'b1000;
      step();
      btn = '0;
      wait_q_empty("frame_before_reset");
      step();
      checks++;
      if (draw_go !== 1'b1 || draw_sel !== 3'd2) begin
         errors++;
         $display("FAIL erase_active: got draw_go=%0b draw_sel=%0d, required 1 2", draw_go, draw_sel);
      end
      resetn = 1'b0;
      step();
      checks++;
      if ({draw_go, draw_sel, map_idx, timer_clr, timer_en, car_update, game_over} !== '0) begin
         errors++;
         $display("FAIL reset_mid_erase: got go=%0b sel=%0d idx=%0d clr=%0b en=%0b upd=%0b over=%0b, required all 0",
                  draw_go, draw_sel, map_idx, timer_clr, timer_en, car_update, game_over);
      end
      cur_idx = 0;
      push(0, 0, 0, -1);
      resetn = 1'b1;
      wait_q_empty("post_reset_start");
      wait_go_low("post_reset_start");
      repeat (5) step();

      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d events outstanding, required 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the VGA racing project. Parametrised successor of the fixed two-map control FSM.
- Sequence: start screen → map select (N maps, one button each) → map draw → frame loop (erase car, update, draw car, frame delay) → game-over screen → restart.
- Drives a single shared drawer through a go/done handshake.
- Owns the frame-delay counter and the game-timer enables.

Parameters:
- NUM_MAPS, 4, number of selectable maps and map buttons (2..8)
- MAP_W, $clog2(NUM_MAPS), width of map index
- FRAME_DELAY, 833333, clk cycles per frame (60 Hz at 50 MHz); minimum 2
- DELAY_W, $clog2(FRAME_DELAY), frame counter width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- btn  in  NUM_MAPS  map/restart buttons, active-high, already synchronised
- draw_done  in  1  one-cycle pulse from drawer when the requested draw has completed
- time_up  in  1  game timer expired (level or pulse)
- draw_go  out  1  drawer request, held high until draw_done
- draw_sel  out  3  drawer job: 0 START, 1 MAP, 2 CAR_ERASE, 3 CAR, 4 GAMEOVER
- map_idx  out  MAP_W  latched selected map
- timer_clr  out  1  one-cycle game-timer clear
- timer_en  out  1  game timer run enable
- car_update  out  1  one-cycle pulse to car position logic
- game_over  out  1  high while in game-over states

Behaviour:
- All outputs are Moore-decoded from registered state, except `map_idx`, which is a register.
- `resetn` = 0 on a clk edge:
  - state ← S_IDLE
  - `map_idx` ← 0, `btn_q` ← 0, frame counter ← 0, `end_pend` ← 0
  - All outputs are 0 in S_IDLE.
- Reset mid-draw abandons the job: `draw_go` drops the next cycle.
- Button edge: `btn_q` ← `btn` every cycle; press = `btn` & ~`btn_q`. Held buttons never re-trigger.
- States and transitions:
  - S_IDLE → S_DRAW_START unconditionally (1 cycle).
  - S_DRAW_START: `draw_go`=1, `draw_sel`=0. On `draw_done` → S_WAIT_SEL.
  - S_WAIT_SEL: on any press bit, `map_idx` ← lowest set index, → S_DRAW_MAP. Multiple simultaneous presses resolve to the lowest index.
  - S_DRAW_MAP: `draw_go`=1, `draw_sel`=1. On `draw_done` → S_START_TIMER.
  - S_START_TIMER: `timer_clr`=1, `end_pend` ← 0, → S_ERASE (1 cycle).
  - S_ERASE: `draw_go`=1, `draw_sel`=2, `timer_en`=1. On `draw_done` → S_UPDATE.
  - S_UPDATE: `car_update`=1, `timer_en`=1, → S_DRAW_CAR (1 cycle).
  - S_DRAW_CAR: `draw_go`=1, `draw_sel`=3, `timer_en`=1. On `draw_done`: counter ← FRAME_DELAY-1, → S_FRAME_WAIT.
  - S_FRAME_WAIT: `timer_en`=1, counter decrements each cycle. At counter = 0:
    - if `end_pend`, or `time_up` this cycle → S_DRAW_OVER
    - else → S_ERASE
  - S_DRAW_OVER: `draw_go`=1, `draw_sel`=4, `game_over`=1. On `draw_done` → S_OVER_WAIT.
  - S_OVER_WAIT: `game_over`=1. On any press → S_DRAW_START. `map_idx` is retained until the next selection.
- `end_pend`:
  - Set on any cycle where `timer_en`=1 and `time_up`=1.
  - Sticky until S_START_TIMER.
  - Game end is therefore only taken at the frame boundary. A frame is never cut mid-draw.
- `draw_done` outside a draw state is ignored.
- `draw_go` stays high for the entire wait. The exiting cycle (when `draw_done`=1) still shows `draw_go`=1; it is 0 the next cycle.
- `draw_sel` is 0 whenever `draw_go`=0.
- Frame loop period = erase latency + 1 + draw latency + FRAME_DELAY cycles.
- Counter never wraps: it is loaded only in S_DRAW_CAR.
- Illegal state encodings → S_IDLE on the next edge.

Decomposition:
- Package `game_pkg`:
  - state enum (11 states)
  - draw job constants DRAW_START=0, DRAW_MAP=1, DRAW_ERASE=2, DRAW_CAR=3, DRAW_OVER=4
  - DRAW_SEL_W=3
- Sub-module `frame_delay_counter`:
  - Parameter FRAME_DELAY; ports clk, resetn, load, en.
  - Output `zero`.
  - Reused later by the enemy-car animator.
- Priority encoder for button index: inline function.

Test Plan (FRAME_DELAY=4, NUM_MAPS=4; drawer model returns `draw_done` 3 cycles after `draw_go` rises):
- Reset release → 1 cycle in S_IDLE with all outputs 0; then `draw_go`=1, `draw_sel`=0 until `draw_done`, then S_WAIT_SEL with `draw_go`=0.
- In S_WAIT_SEL, `btn`=4'b0110 for one cycle → `map_idx`=1, `draw_sel`=1. After `draw_done`: exactly one `timer_clr` pulse, then `draw_sel`=2 with `timer_en`=1.
- Hold `btn`[2] high from before S_WAIT_SEL entry and never release → no map selection. Release then re-press `btn`[2] → `map_idx`=2.
- Steady loop:
  - `car_update` pulses once per frame.
  - Period = 3+1+3+4 = 11 cycles, measured from `car_update` to the next `car_update`.
  - `timer_en` stays high throughout.
- `time_up` pulsed for one cycle during S_DRAW_CAR → current frame completes (S_FRAME_WAIT, 4 cycles) → `draw_sel`=4, `game_over`=1, `timer_en`=0. No further `car_update`.
- In S_OVER_WAIT press `btn`[3] → `draw_sel`=0. Select map 0 → `timer_clr` pulse clears `end_pend`; loop runs ≥3 frames without game over. Assert `resetn`=0 mid S_ERASE → next cycle all outputs 0.
